// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data ports, 1-cycle read responses.
// Optional fetch starvation guard compiled in with MEM_ARB_FAIRNESS_EN.
module mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_valid_o,
  output logic                  stall_if_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_valid_o,
  output logic                  stall_dm_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    R_NONE = 2'd0,
    R_IF   = 2'd1,
    R_DM   = 2'd2
  } resp_e;

  resp_e                 r_state;
  resp_e                 w_state_next;
  logic                  w_force_if;
  logic                  w_grant_if;
  logic                  w_grant_dm;
  logic [DATA_WIDTH-1:0] r_if_hold;
  logic [DATA_WIDTH-1:0] r_dm_hold;

  // Data wins a conflict unless fetch has lost too many in a row.
  assign w_grant_dm = dm_req_i & ~(if_req_i & w_force_if);
  assign w_grant_if = if_req_i & ~w_grant_dm;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve;

  assign w_force_if = (r_starve == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve <= '0;
    end else if (!if_req_i || w_grant_if) begin
      r_starve <= '0;
    end else if (dm_req_i && (r_starve != CNT_W'(STARVE_LIMIT))) begin
      r_starve <= r_starve + CNT_W'(1);
    end
  end
`else
  assign w_force_if = 1'b0;
`endif

  assign stall_if_o  = if_req_i & ~w_grant_if;
  assign stall_dm_o  = dm_req_i & ~w_grant_dm;
  assign mem_en_o    = w_grant_if | w_grant_dm;
  assign mem_we_o    = w_grant_dm & dm_we_i;
  assign mem_addr_o  = w_grant_dm ? dm_addr_i : if_addr_i;
  assign mem_wdata_o = dm_wdata_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= R_NONE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = R_NONE;
    if_valid_o   = 1'b0;
    dm_valid_o   = 1'b0;
    if (w_grant_if) begin
      w_state_next = R_IF;
    end else if (w_grant_dm && !dm_we_i) begin
      w_state_next = R_DM;
    end
    case (r_state)
      R_IF:    if_valid_o = 1'b1;
      R_DM:    dm_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Response data is forwarded in its valid cycle and held afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_if_hold <= '0;
      r_dm_hold <= '0;
    end else begin
      if (r_state == R_IF) r_if_hold <= mem_rdata_i;
      if (r_state == R_DM) r_dm_hold <= mem_rdata_i;
    end
  end

  assign if_rdata_o = if_valid_o ? mem_rdata_i : r_if_hold;
  assign dm_rdata_o = dm_valid_o ? mem_rdata_i : r_dm_hold;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-ported synchronous memory between the instruction-fetch port and the data-memory port of the pipelined core. It issues at most one access per cycle and routes each 1-cycle-latency read response back to its owner. It drives per-port stall signals that feed the hazard/enable logic of the PC register and the pipeline registers. Data accesses have priority by default, with an optional starvation guard for fetch.

## Interface
- DATA_WIDTH, 32, width of memory data words
- ADDR_WIDTH, 32, width of byte addresses (passed through unmodified)
- STARVE_LIMIT, 4, consecutive lost fetch conflicts before fetch is forced (≥1; used only with fairness compiled in)

- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request; held until not stalled
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_rdata_o  out  DATA_WIDTH  fetched word, registered, held between responses
- if_valid_o  out  1  one-cycle pulse, if_rdata_o is new
- stall_if_o  out  1  fetch request present but not granted this cycle
- dm_req_i  in  1  data request; held until not stalled
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_WIDTH  data address
- dm_wdata_i  in  DATA_WIDTH  write data
- dm_rdata_o  out  DATA_WIDTH  read data, registered, held between responses
- dm_valid_o  out  1  one-cycle pulse, dm_rdata_o is new (reads only)
- stall_dm_o  out  1  data request present but not granted this cycle
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid the cycle after a read issue

## Operation
- Grant decision is combinational each cycle:
  - Only one port requesting: that port wins.
  - Both requesting: dm wins, unless the fairness override is active (see Configuration).
- The granted port's address, write enable and write data drive the mem_* outputs. mem_en_o = grant valid. mem_we_o = dm granted && dm_we_i.
- stall_x_o = x_req_i && !grant_x. This is combinational, with no registered delay.
- Response owner FSM (registered), with states R_NONE, R_IF, R_DM:
  - Next state is R_IF on a fetch issue, R_DM on a data read issue, R_NONE otherwise (idle or data write).
  - In R_IF: if_rdata_o <= mem_rdata_i and if_valid_o = 1 for that cycle.
  - In R_DM: dm_rdata_o <= mem_rdata_i and dm_valid_o = 1 for that cycle.
  - Response capture and a new issue occur in the same cycle (back-to-back, full throughput).
- Writes complete at issue. No response and no valid pulse.
- Write then read of the same address on consecutive cycles: issued in order. Read-after-write correctness is the memory's responsibility.
- Addresses and data are passed through untouched, with no alignment checks.

## Timing
- Read latency: issue in cycle N, valid pulse and data on the output registers in cycle N+1. The result is visible to the consumer at the N+1 edge.
- Stall has 0-cycle latency from the request inputs.
- Reset (rst_i low, asynchronous):
  - FSM to R_NONE.
  - if_valid_o, dm_valid_o = 0.
  - if_rdata_o, dm_rdata_o = 0.
  - Starvation counter = 0.
  - mem_*, stall_* follow the request inputs combinationally; mem_en_o = 0 when no request.
- Reset mid-operation: an outstanding read response is dropped and no valid pulse follows reset release.
- After reset release, the first grant is possible in the same cycle.

## Configuration
- MEM_ARB_FAIRNESS_EN defined:
  - A counter (width $clog2(STARVE_LIMIT+1)) increments each cycle both ports request and dm wins.
  - It saturates at STARVE_LIMIT.
  - When it equals STARVE_LIMIT and both ports request, fetch wins.
  - The counter clears on any fetch grant, or any cycle with if_req_i = 0.
- MEM_ARB_FAIRNESS_EN undefined:
  - Strict dm priority; no counter is instantiated.
  - Fetch may stall indefinitely under continuous data requests.

## Test plan
- Reset then fetch only, if_addr 0x0 with mem_rdata 0x00500093:
  - Cycle N: mem_en=1, mem_addr=0x0, stall_if=0.
  - Cycle N+1: if_valid=1, if_rdata=0x00500093.
- Simultaneous if_req and dm read (addr 0x100):
  - Cycle N: dm granted, stall_if=1, stall_dm=0.
  - Cycle N+1: dm_valid=1; fetch granted, mem_addr = fetch address.
- dm write, we=1, addr 0x104, wdata 0xDEADBEEF:
  - mem_we=1 and mem_wdata=0xDEADBEEF in the issue cycle.
  - No dm_valid pulse next cycle.
- Back-to-back alternating grants for 6 cycles: each response is routed to the correct port, with no lost or duplicated valid pulses.
- Both ports held requesting continuously, STARVE_LIMIT=4:
  - With MEM_ARB_FAIRNESS_EN: fetch is granted on the 5th cycle, then the counter restarts.
  - Without it: stall_if stays 1 throughout.
- Assert rst_i low asynchronously the cycle after a dm read issue:
  - dm_valid stays 0, dm_rdata = 0.
  - After release, the first new request is granted the same cycle.
